// File: rtl/init_regbank_v2.sv
// init_regbank_v2: AXI4-Lite slave bank of NUM_REGS read/write control registers.
//   Clock/reset : s00_axi_aclk, s00_axi_aresetn (synchronous, active-low)
//   AXI4-Lite   : AW/W/B write channels and AR/R read channels, prot ignored
//   reg_out     : flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse: one-cycle pulse per register on an accepted in-range write
//   Optional    : define INIT_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR
module init_regbank_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int STRB     = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB);
  localparam int IDXW     = ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDXW:0] NREG = (IDXW+1)'(NUM_REGS);
  localparam logic [1:0] RESP_OK = 2'b00;
`ifdef INIT_REGBANK_SLVERR_EN
  localparam logic [1:0] RESP_ERR = 2'b10;
`else
  localparam logic [1:0] RESP_ERR = 2'b00;
`endif

  // *_INIT states keep the ready outputs low for the first cycle after reset release
  typedef enum logic [2:0] {W_INIT, W_IDLE, W_GOT_A, W_GOT_D, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_t;

  w_state_t                             r_wst;
  r_state_t                             r_rst;
  logic                                 r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                           r_bresp, r_rresp;
  logic [IDXW-1:0]                      r_awidx;
  logic [DATA_WIDTH-1:0]                r_wdata, r_rdata;
  logic [STRB-1:0]                      r_wstrb;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r_regs;
  logic [NUM_REGS-1:0]                  r_pulse;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wok, w_rok;
  logic [IDXW-1:0]       w_widx, w_ridx;
  logic [DATA_WIDTH-1:0] w_wdata, w_rsel;
  logic [STRB-1:0]       w_wstrb;
  logic                  w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

  assign w_aw_hs = s00_axi_awvalid & r_awready;
  assign w_w_hs  = s00_axi_wvalid & r_wready;
  assign w_ar_hs = s00_axi_arvalid & r_arready;
  // Commit happens on the edge that completes the AW/W pair, whichever order they came in
  assign w_commit = (r_wst == W_IDLE  && w_aw_hs && w_w_hs) ||
                    (r_wst == W_GOT_A && w_w_hs) ||
                    (r_wst == W_GOT_D && w_aw_hs);
  assign w_widx  = (r_wst == W_GOT_A) ? r_awidx : s00_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_wdata = (r_wst == W_GOT_D) ? r_wdata : s00_axi_wdata;
  assign w_wstrb = (r_wst == W_GOT_D) ? r_wstrb : s00_axi_wstrb;
  assign w_wok   = {1'b0, w_widx} < NREG;
  assign w_ridx  = s00_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_rok   = {1'b0, w_ridx} < NREG;

  // Read mux falls through to zero for out-of-range indices
  always_comb begin
    w_rsel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_ridx == IDXW'(i)) w_rsel = r_regs[i];
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_wst     <= W_INIT;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OK;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_wst     <= W_RESP;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wok ? RESP_OK : RESP_ERR;
    end else begin
      case (r_wst)
        W_INIT: begin
          r_wst     <= W_IDLE;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
        end
        W_IDLE:
          if (w_aw_hs) begin
            r_wst     <= W_GOT_A;
            r_awready <= 1'b0;
            r_awidx   <= w_widx;
          end else if (w_w_hs) begin
            r_wst    <= W_GOT_D;
            r_wready <= 1'b0;
            r_wdata  <= s00_axi_wdata;
            r_wstrb  <= s00_axi_wstrb;
          end
        W_RESP:
          if (s00_axi_bready) begin
            r_wst     <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_regs  <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (w_commit && w_wok && w_widx == IDXW'(i)) begin
          r_pulse[i] <= 1'b1;
          for (int b = 0; b < STRB; b++)
            if (w_wstrb[b]) r_regs[i][8*b +: 8] <= w_wdata[8*b +: 8];
        end
    end
  end

  // rdata is sampled from the pre-commit register values, so a same-edge write is not visible
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_rst     <= R_INIT;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OK;
      r_rdata   <= '0;
    end else begin
      case (r_rst)
        R_INIT: begin
          r_rst     <= R_IDLE;
          r_arready <= 1'b1;
        end
        R_IDLE:
          if (w_ar_hs) begin
            r_rst     <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rsel;
            r_rresp   <= w_rok ? RESP_OK : RESP_ERR;
          end
        R_DATA:
          if (s00_axi_rready) begin
            r_rst     <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rresp   = r_rresp;
  assign s00_axi_rdata   = r_rdata;
  assign reg_out         = r_regs;
  assign reg_wr_pulse    = r_pulse;
endmodule

// File: tb/tb_init_regbank_v2.sv
// tb_init_regbank_v2: directed self-checking bench for init_regbank_v2 (32-bit, 4 registers).
module tb_init_regbank_v2;
`ifdef INIT_REGBANK_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [9:0]   awaddr = '0, araddr = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;
  int           n_chk = 0, n_err = 0;
  logic [1:0]   g_bresp, g_rresp;
  logic [31:0]  g_rdata;
  logic [3:0]   g_pulse, g_pulse_after;
  logic         ok;

  init_regbank_v2 dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    logic aw_ok, w_ok;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk); aw_ok = awready; w_ok = wready;
      @(posedge clk); #1;
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 20);
    if (!bvalid) check("b_timeout", 0, 1);
    g_bresp = bresp; g_pulse = reg_wr_pulse;
    @(posedge clk); #1;
    @(negedge clk); g_pulse_after = reg_wr_pulse;
  endtask

  task automatic rd(input logic [9:0] a);
    int n;
    logic ar_ok;
    araddr = a; arvalid = 1'b1; n = 0;
    while (arvalid && n < 20) begin
      @(negedge clk); ar_ok = arready;
      @(posedge clk); #1;
      if (ar_ok) arvalid = 1'b0;
      n++;
    end
    arvalid = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    if (!rvalid) check("r_timeout", 0, 1);
    g_rdata = rdata; g_rresp = rresp;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_regout", reg_out, 0);
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid, reg_wr_pulse}, 0);
    check("rst_resp", {bresp, rresp, rdata}, 0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(negedge clk); check("post_rst_ready_low", {awready, wready, arready}, 3'b000);
    @(negedge clk); check("post_rst_ready_high", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 4; i++) begin
      wr(10'(4*i), 32'(i+1), 4'hF);
      check("wr_bresp", g_bresp, 0);
    end
    for (int i = 0; i < 4; i++) begin
      rd(10'(4*i));
      check("rd_data", g_rdata, 32'(i+1));
      check("rd_rresp", g_rresp, 0);
    end
    check("regout_1234", reg_out, 128'h00000004_00000003_00000002_00000001);

    wr(10'h4, 32'hAABBCCDD, 4'hF);
    check("strb_pulse1", g_pulse, 4'b0010);
    check("strb_pulse1_after", g_pulse_after, 4'b0000);
    wr(10'h4, 32'h11223344, 4'h5);
    check("strb_pulse2", g_pulse, 4'b0010);
    check("strb_pulse2_after", g_pulse_after, 4'b0000);
    rd(10'h4);
    check("strb_merge", g_rdata, 32'hAA22CC44);

    @(posedge clk); #1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); check("wfirst_wready", wready, 1'b1);
    @(posedge clk); #1; wvalid = 1'b0;
    repeat (2) @(posedge clk); #1;
    awaddr = 10'h8; awvalid = 1'b1;
    @(negedge clk); check("wfirst_ready_state", {awready, wready, bvalid}, 3'b100);
    @(posedge clk); #1; awvalid = 1'b0;
    @(negedge clk);
    check("wfirst_bvalid", bvalid, 1'b1);
    check("wfirst_reg2", reg_out[2*32 +: 32], 32'hDEADBEEF);
    check("wfirst_pulse", reg_wr_pulse, 4'b0100);
    @(posedge clk); #1;

    bready = 1'b0;
    awaddr = 10'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awaddr = 10'hC; wdata = 32'h77;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); ok &= bvalid & ~awready & ~wready;
      @(posedge clk); #1;
    end
    check("bhold_stall", ok, 1'b1);
    check("bhold_reg3_unchanged", reg_out[3*32 +: 32], 32'h4);
    check("bhold_reg0", reg_out[31:0], 32'h55);
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); check("bhold_ready_back", {awready, wready, bvalid}, 3'b110);
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bhold_second_bvalid", bvalid, 1'b1);
    check("bhold_reg3", reg_out[3*32 +: 32], 32'h77);
    @(posedge clk); #1;

    wr(10'h10, 32'hCAFEF00D, 4'hF);
    check("oor_bresp", g_bresp, ERR);
    check("oor_pulse", g_pulse, 4'b0000);
    check("oor_regout", reg_out, 128'h00000077_DEADBEEF_AA22CC44_00000055);
    rd(10'h10);
    check("oor_rresp", g_rresp, ERR);
    check("oor_rdata", g_rdata, 0);

    wr(10'h0, 32'h5, 4'hF);
    @(posedge clk); #1;
    awaddr = 10'h0; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 10'h0; arvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("coll_valids", {rvalid, bvalid}, 2'b11);
    check("coll_old_data", rdata, 32'h5);
    @(posedge clk); #1;
    rd(10'h0);
    check("coll_new_data", g_rdata, 32'h9);

    awaddr = 10'h4; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; aresetn = 1'b0;
    @(posedge clk); #1; aresetn = 1'b1;
    @(negedge clk);
    check("midrst_regout", reg_out, 0);
    check("midrst_out", {bvalid, awready, wready, reg_wr_pulse}, 0);
    @(negedge clk);
    check("midrst_idle", {awready, wready, arready}, 3'b111);
    repeat (2) @(negedge clk);
    check("midrst_no_commit", {reg_out, bvalid}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
